// File: rtl/block_serializer.sv
`timescale 1ns/1ps
// block_serializer: accepts a NUM_BYTES-wide cipher block and hands it, LSB
// byte first, to a UART transmitter using a tx_start/tx_busy handshake.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   blk_valid/ready - block handshake; blk_data holds byte k at [8k+7:8k]
//   tx_busy         - transmitter busy flag
//   tx_start        - one-cycle start pulse, tx_data the byte being sent
//   done            - one-cycle pulse once the whole block has drained
module block_serializer #(
    parameter int unsigned NUM_BYTES   = 8,
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   blk_valid,
    input  logic [8*NUM_BYTES-1:0] blk_data,
    output logic                   blk_ready,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic                   done
);

    localparam int unsigned BLK_W = 8 * NUM_BYTES;
    localparam int unsigned CNT_W = $clog2(NUM_BYTES + 1);
    localparam int unsigned TO_W  = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_ACK    = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [BLK_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [TO_W-1:0]  to_q, to_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             done_q, done_d;
    logic             blk_ready_q, blk_ready_d;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        to_d        = to_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        done_d      = 1'b0;
        blk_ready_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (blk_valid) begin
                    shreg_d = blk_data;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                // Shift register always presents the current byte in its low 8 bits
                if (!tx_busy) begin
                    tx_data_d  = shreg_q[7:0];
                    shreg_d    = shreg_q >> 8;
                    tx_start_d = 1'b1;
                    to_d       = '0;
                    state_d    = S_ACK;
                end
            end
            S_ACK: begin
                // Give up waiting for busy after ACK_TIMEOUT cycles in this state
                if (tx_busy || (to_q == TO_W'(ACK_TIMEOUT - 1))) begin
                    state_d = S_DRAIN;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_DRAIN: begin
                if (!tx_busy) begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == CNT_W'(NUM_BYTES)) ? S_FINISH : S_START;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d      = (state_d == S_FINISH);
        blk_ready_d = (state_d == S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            to_q        <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            done_q      <= 1'b0;
            blk_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            done_q      <= done_d;
            blk_ready_q <= blk_ready_d;
        end
    end

    assign blk_ready = blk_ready_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_block_serializer.sv
`timescale 1ns/1ps
// tb_block_serializer: scoreboard bench for block_serializer. Inputs are
// driven 1ns after the rising edge; the monitor samples on the falling edge.
module tb_block_serializer;

    localparam int unsigned NB = 8;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        blk_valid;
    logic [63:0] blk_data;
    logic        blk_ready;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        done;

    logic        xmit_busy   = 1'b0;
    logic        glitch_busy = 1'b0;
    logic        hold_busy;
    assign tx_busy = xmit_busy | hold_busy | glitch_busy;

    logic        blk_valid1;
    logic [7:0]  blk_data1;
    logic        blk_ready1;
    logic        tx_busy1;
    logic        tx_start1;
    logic [7:0]  tx_data1;
    logic        done1;
    assign tx_busy1 = 1'b0;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [7:0] exp_q[$];
    int  start_times[$];
    bit  in_xfer = 1'b0;
    int  nbytes = 0;
    int  start_count = 0;
    int  done_count = 0;
    int  accept_cycle = 0;
    int  last_done_cycle = -1000;
    int  last_accept_gap = 0;
    bit  prev_start = 1'b0;
    bit  prev_done = 1'b0;
    bit  prev_busy = 1'b0;
    logic [7:0] last_data = 8'h00;

    int  busy_len = 10;
    bit  glitch_en = 1'b0;

    int  starts1 = 0;
    int  dones1 = 0;
    logic [7:0] data1 = 8'h00;

    always #5 clk = ~clk;

    block_serializer #(.NUM_BYTES(NB), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_data(blk_data),
        .blk_ready(blk_ready), .tx_busy(tx_busy), .tx_start(tx_start),
        .tx_data(tx_data), .done(done)
    );

    block_serializer #(.NUM_BYTES(1), .ACK_TIMEOUT(TO)) dut1 (
        .clk(clk), .rst(rst), .blk_valid(blk_valid1), .blk_data(blk_data1),
        .blk_ready(blk_ready1), .tx_busy(tx_busy1), .tx_start(tx_start1),
        .tx_data(tx_data1), .done(done1)
    );

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transmitter model: busy for busy_len cycles after each start pulse
    always begin
        int cnt;
        @(posedge clk);
        #1;
        if (rst) cnt = 0;
        else if (tx_start && busy_len > 0) cnt = busy_len;
        else if (cnt > 0) cnt--;
        xmit_busy = (cnt > 0);
    end

    // Random single-cycle busy glitches
    always begin
        @(posedge clk);
        #1;
        glitch_busy = glitch_en && ($urandom_range(0, 3) == 0);
    end

    // Monitor and scoreboard
    always @(negedge clk) begin
        logic [7:0] exp_b;
        cycle++;
        if (rst) begin
            chk({tx_start, done, blk_ready, tx_data} == 11'h100, "reset_outputs",
                64'({tx_start, done, blk_ready, tx_data}), 64'h100);
            exp_q.delete();
            in_xfer    = 1'b0;
            nbytes     = 0;
            prev_start = 1'b0;
            prev_done  = 1'b0;
            prev_busy  = 1'b0;
            last_data  = 8'h00;
        end else begin
            chk(blk_ready == !in_xfer, "blk_ready", 64'(blk_ready), 64'(!in_xfer));
            if (tx_start) begin
                chk(!prev_start, "start_one_cycle", 64'(prev_start), 64'd0);
                chk(!prev_busy, "start_while_busy", 64'(prev_busy), 64'd0);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_start", 64'(tx_data), 64'd0);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk(tx_data == exp_b, "tx_byte", 64'(tx_data), 64'(exp_b));
                end
                nbytes++;
                start_count++;
                start_times.push_back(cycle);
            end else begin
                chk(tx_data == last_data, "tx_data_hold", 64'(tx_data), 64'(last_data));
            end
            if (done) begin
                chk(!prev_done, "done_one_cycle", 64'(prev_done), 64'd0);
                chk(in_xfer && nbytes == NB && exp_q.size() == 0, "done_after_all_bytes",
                    64'(nbytes), 64'(NB));
                in_xfer = 1'b0;
                nbytes = 0;
                done_count++;
                last_done_cycle = cycle;
            end
            if (blk_valid && blk_ready) begin
                for (int k = 0; k < NB; k++) exp_q.push_back(blk_data[8*k +: 8]);
                in_xfer = 1'b1;
                nbytes = 0;
                last_accept_gap = cycle - last_done_cycle;
                accept_cycle = cycle;
            end
            prev_start = tx_start;
            prev_done  = done;
            prev_busy  = tx_busy;
            last_data  = tx_data;
        end
    end

    // Monitor for the single-byte instance
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start1) begin
                starts1++;
                data1 = tx_data1;
            end
            if (done1) dones1++;
        end
    end

    task automatic send_block(input logic [63:0] d, input bit hold);
        int n;
        n = 0;
        blk_valid = 1'b1;
        blk_data  = d;
        @(negedge clk);
        while (!blk_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(blk_ready == 1'b1, "accept_timeout", 64'(blk_ready), 64'd1);
        @(posedge clk);
        #1;
        blk_valid = hold;
        if (!hold) blk_data = {$urandom, $urandom};
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while ((in_xfer || !blk_ready) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(!in_xfer, "idle_timeout", 64'(in_xfer), 64'd0);
    endtask

    initial begin
        int s0, d0, base, n;
        rst = 1'b1;
        blk_valid = 1'b0;
        blk_data = '0;
        hold_busy = 1'b0;
        blk_valid1 = 1'b0;
        blk_data1 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Known block, 10-cycle busy per byte
        busy_len = 10;
        s0 = start_count; d0 = done_count;
        send_block(64'h0123456789ABCDEF, 1'b0);
        wait_idle();
        chk(start_count - s0 == 8, "kb_starts", 64'(start_count - s0), 64'd8);
        chk(done_count - d0 == 1, "kb_dones", 64'(done_count - d0), 64'd1);

        // Transmitter busy at acceptance for 50 cycles
        busy_len = 5;
        hold_busy = 1'b1;
        s0 = start_count;
        send_block(64'h0123456789ABCDEF, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        chk(start_count == s0, "no_start_while_held", 64'(start_count - s0), 64'd0);
        hold_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk(tx_start == 1'b1 && tx_data == 8'hEF, "first_byte_after_release",
            64'({tx_start, tx_data}), 64'h1EF);
        wait_idle();

        // Transmitter never busy: each byte advances on the ack timeout
        busy_len = 0;
        base = start_times.size();
        s0 = start_count; d0 = done_count;
        send_block({$urandom, $urandom}, 1'b0);
        wait_idle();
        chk(start_count - s0 == NB, "to_starts", 64'(start_count - s0), 64'(NB));
        chk(done_count - d0 == 1, "to_dones", 64'(done_count - d0), 64'd1);
        if (start_times.size() >= base + NB) begin
            chk(start_times[base] - accept_cycle == 2, "accept_to_start_latency",
                64'(start_times[base] - accept_cycle), 64'd2);
            for (int i = 1; i < NB; i++)
                chk(start_times[base+i] - start_times[base+i-1] == TO + 2, "timeout_interval",
                    64'(start_times[base+i] - start_times[base+i-1]), 64'(TO + 2));
        end

        // Reset in the middle of a block, then a fresh block
        busy_len = 3;
        s0 = start_count;
        send_block(64'h1122334455667788, 1'b0);
        n = 0;
        while (start_count < s0 + 3 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk(start_count == s0 + 3, "third_start_seen", 64'(start_count - s0), 64'd3);
        #1;
        rst = 1'b1;
        #1;
        chk({tx_start, done, blk_ready, tx_data} == 11'h100, "async_reset_outputs",
            64'({tx_start, done, blk_ready, tx_data}), 64'h100);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        s0 = start_count; d0 = done_count;
        send_block(64'hFFEEDDCCBBAA9988, 1'b0);
        wait_idle();
        chk(start_count - s0 == NB, "post_reset_starts", 64'(start_count - s0), 64'(NB));
        chk(done_count - d0 == 1, "post_reset_dones", 64'(done_count - d0), 64'd1);

        // Back-to-back blocks with blk_valid held high
        busy_len = 2;
        s0 = start_count; d0 = done_count;
        send_block(64'hA5A4A3A2A1A0A9A8, 1'b1);
        send_block(64'h5F5E5D5C5B5A5958, 1'b0);
        chk(last_accept_gap == 1, "b2b_accept_after_done", 64'(last_accept_gap), 64'd1);
        wait_idle();
        chk(start_count - s0 == 16, "b2b_starts", 64'(start_count - s0), 64'd16);
        chk(done_count - d0 == 2, "b2b_dones", 64'(done_count - d0), 64'd2);

        // Randomized blocks, busy lengths and busy glitches
        s0 = start_count; d0 = done_count;
        for (int b = 0; b < 25; b++) begin
            int gap;
            busy_len = $urandom_range(0, 6);
            glitch_en = ($urandom_range(0, 1) == 1);
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send_block({$urandom, $urandom}, 1'b0);
        end
        wait_idle();
        glitch_en = 1'b0;
        chk(start_count - s0 == 25 * NB, "rand_starts", 64'(start_count - s0), 64'(25 * NB));
        chk(done_count - d0 == 25, "rand_dones", 64'(done_count - d0), 64'd25);

        // Single-byte instance
        blk_valid1 = 1'b1;
        blk_data1 = 8'h5A;
        @(posedge clk);
        #1;
        blk_valid1 = 1'b0;
        blk_data1 = 8'hC3;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        chk(starts1 == 1, "nb1_starts", 64'(starts1), 64'd1);
        chk(data1 == 8'h5A, "nb1_byte", 64'(data1), 64'h5A);
        chk(dones1 == 1, "nb1_dones", 64'(dones1), 64'd1);
        chk(blk_ready1 == 1'b1, "nb1_ready", 64'(blk_ready1), 64'd1);

        chk(exp_q.size() == 0, "scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/block_serializer.md
BLOCK_SERIALIZER -- requirements
Module: block_serializer

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 8, the number of bytes per block; legal range 1..16.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 4, the maximum number of cycles to wait for tx_busy to rise after a tx_start pulse; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port blk_valid, input, 1, indicating that a cipher block is presented on blk_data.
REQ-006 SHALL have port blk_data, input, 8*NUM_BYTES, the cipher block; byte k is blk_data[8k+7:8k].
REQ-007 SHALL have port blk_ready, output, 1, high when the block can accept a new block.
REQ-008 SHALL have port tx_busy, input, 1, the busy flag from the UART transmitter.
REQ-009 SHALL have port tx_start, output, 1, a one-cycle start pulse to the UART transmitter.
REQ-010 SHALL have port tx_data, output, 8, the byte sent to the UART transmitter.
REQ-011 SHALL have port done, output, 1, a one-cycle pulse after the last byte has been handed off and the transmitter has gone idle.

Function
REQ-012 SHALL implement the states IDLE, START, ACK, DRAIN and FINISH.
REQ-013 SHALL assert blk_ready only in IDLE; the block is accepted when blk_valid=1 and blk_ready=1 on the same edge.
REQ-014 On acceptance, SHALL capture blk_data into an internal shift register, clear the byte counter to 0 and go to START; later changes on blk_data SHALL have no effect until the next acceptance.
REQ-015 In START, SHALL wait while tx_busy=1.
REQ-016 In START, when tx_busy=0, SHALL drive tx_data with byte[counter], pulse tx_start for exactly one cycle and go to ACK.
REQ-017 SHALL hold tx_data stable from the tx_start cycle until the next byte is loaded.
REQ-018 In ACK, SHALL go to DRAIN when tx_busy=1, or after ACK_TIMEOUT cycles without tx_busy=1; the timeout counter is 4 bits and clears on entering ACK.
REQ-019 In DRAIN, SHALL wait for tx_busy=0, then increment the byte counter.
REQ-020 In DRAIN, once the incremented counter equals NUM_BYTES, SHALL go to FINISH; otherwise it SHALL go to START.
REQ-021 In FINISH, SHALL assert done for exactly one cycle, then return to IDLE with blk_ready=1 on the next cycle.
REQ-022 SHALL send bytes least-significant byte first: byte 0, then byte 1, up to byte NUM_BYTES-1; no byte is skipped or repeated.
REQ-023 SHALL use a byte counter of clog2(NUM_BYTES+1) bits that never exceeds NUM_BYTES.
REQ-024 SHALL ignore blk_valid in any state other than IDLE; the producer must hold the block until it is accepted.
REQ-025 If blk_valid=1 is held through FINISH, SHALL accept the next block in the first IDLE cycle; back-to-back blocks therefore have at least one IDLE cycle between them.
REQ-026 The latency from acceptance to the first tx_start SHALL be 1 cycle when tx_busy=0.
REQ-027 Any tx_busy glitch in START that lasts less than one cycle SHALL have no effect beyond that sampled cycle.

Reset
REQ-028 While rst=1, regardless of clk, SHALL force state=IDLE, tx_start=0, tx_data=8'h00, done=0, counter=0, the shift register to 0 and blk_ready=1.
REQ-029 A reset asserted mid-block SHALL abandon the block with no further tx_start; after rst deasserts, the next transfer SHALL start again from byte 0.
REQ-030 The release of rst SHALL be synchronous to clk by the integrator; the block adds no reset synchronizer.

Verification
REQ-031 Block 64'h0123456789ABCDEF, model transmitter busy for 10 cycles per byte -> tx_data sequence EF,CD,AB,89,67,45,23,01, 8 tx_start pulses, exactly one done.
REQ-032 tx_busy held at 1 for 50 cycles at acceptance -> no tx_start until tx_busy=0, then first byte EF issued within 1 cycle.
REQ-033 Transmitter never asserts tx_busy -> each byte advances after ACK_TIMEOUT=4 cycles, all 8 bytes sent, done asserted.
REQ-034 Assert rst after the 3rd tx_start, then send block 64'hFFEEDDCCBBAA9988 -> outputs reset immediately, and the new transfer begins with byte 88 and reaches done.
REQ-035 blk_valid held high with two consecutive blocks -> second block accepted on the cycle after done, blk_ready low throughout each transfer, 16 bytes in order.
REQ-036 NUM_BYTES=1, block 8'h5A -> single tx_start with tx_data=5A, then done.
